control_multi_fsm: RTL and testbench
====================================

Name: control_multi_fsm

Overview:
- Multicycle LEGv8 control unit: a Moore FSM that sequences the shared datapath (one memory for instructions and data, one ALU, register bank, IR, A/B/ALUOut/MDR latches) through FETCH/DECODE/EXEC/MEM/WB.
- Decodes the 11-bit opcode from IR, drives every mux select and write enable, and stalls on a memory-ready handshake.
- Sits between IR and datapath in the multicycle CPU top.

Parameters:
- ALUOP_W, 2, ALU operation field width (00 add, 01 pass B, 10 decode from opcode).
- ST_W, 4, width of the exported state code.

Ports:
- iCLK  in  1  system clock, rising edge.
- iRST_n  in  1  asynchronous active-low reset.
- iOPCODE  in  11  IR[31:21]; valid from DECODE onward.
- iZero  in  1  ALU zero flag.
- iMemReady  in  1  memory completed current read/write this cycle.
- oPCWrite  out  1  PC load enable.
- oIorD  out  1  memory address: 0=PC, 1=ALUOut.
- oMemRead  out  1  memory read request.
- oMemWrite  out  1  memory write request.
- oIRWrite  out  1  IR load enable.
- oReg2Loc  out  1  2nd read register: 0=Rm, 1=Rt.
- oOrigAULA  out  1  ALU A: 0=PC, 1=register A.
- oOrigBULA  out  2  ALU B: 00=reg B, 01=const 4, 10=sign-ext imm, 11=branch offset<<2.
- oALUop  out  ALUOP_W  ALU control class.
- oOrigPC  out  1  PC source: 0=ALU result, 1=ALUOut.
- oMemToReg  out  1  write-back: 0=ALUOut, 1=MDR.
- oRegWrite  out  1  register bank write enable.
- oIllegal  out  1  sticky unsupported-opcode flag.
- oState  out  ST_W  current state code (debug).

Behaviour:
- States and codes: IDLE=0, FETCH=1, DECODE=2, EXEC_R=3, EXEC_I=4, MEM_ADDR=5, MEM_RD=6, MEM_WR=7, WB_ALU=8, WB_MEM=9, BRANCH=10, JUMP=11.
- Reset (async, iRST_n=0): state←IDLE, class register cleared, oIllegal←0. In IDLE all outputs are 0 and oState=0. IDLE→FETCH on the first edge after release.
- Outputs are Moore-decoded from the registered state, plus the latched class and iZero in BRANCH. Every output not listed for a state is 0.
- FETCH: oMemRead=1, oIorD=0, oOrigAULA=0, oOrigBULA=01, oALUop=00.
  - oIRWrite and oPCWrite (oOrigPC=0) assert only in the cycle iMemReady=1.
  - Stay in FETCH while iMemReady=0; go to DECODE when it is 1.
- DECODE: oOrigAULA=0, oOrigBULA=11, oALUop=00 (branch target into ALUOut); oReg2Loc=1 for CBZ/CBNZ/STUR.
  - Latch class from iOPCODE using the shared OPC_* constants, matched with casez.
  - R (ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000, EOR 11001010000) → EXEC_R.
  - I (ADDI/SUBI/ANDI/ORRI/EORI, low bit don't-care) → EXEC_I.
  - LDUR 11111000010 / STUR 11111000000 → MEM_ADDR.
  - CBZ 10110100xxx / CBNZ 10110101xxx → BRANCH.
  - B 000101xxxxx → JUMP.
  - Anything else: set oIllegal, go to FETCH (PC already advanced).
- EXEC_R: oOrigAULA=1, oOrigBULA=00, oALUop=10 → WB_ALU.
- EXEC_I: oOrigAULA=1, oOrigBULA=10, oALUop=10 → WB_ALU.
- WB_ALU: oRegWrite=1, oMemToReg=0 → FETCH.
- MEM_ADDR: oOrigAULA=1, oOrigBULA=10, oALUop=00 → MEM_RD (load) or MEM_WR (store).
- MEM_RD: oMemRead=1, oIorD=1; hold until iMemReady=1, then → WB_MEM.
- WB_MEM: oRegWrite=1, oMemToReg=1 → FETCH.
- MEM_WR: oMemWrite=1, oIorD=1, oReg2Loc=1; hold until iMemReady=1, then → FETCH.
  - oMemWrite stays asserted, with address and data stable, for the whole wait.
- BRANCH: oReg2Loc=1, oOrigBULA=00, oALUop=01 (pass Rt).
  - oPCWrite = (CBZ & iZero) | (CBNZ & ~iZero), oOrigPC=1 → FETCH.
- JUMP: oPCWrite=1, oOrigPC=1 → FETCH. DECODE uses the B offset path; the datapath's sign-extender selects the field by opcode.
- Latency with zero-wait memory: R/I 4 cycles, LDUR 5, STUR 4, CBZ/CBNZ/B 3. Each memory wait cycle adds 1.
- Hazard rules:
  - oMemRead and oMemWrite are never high together.
  - oRegWrite and oPCWrite are never high in a wait cycle.
  - iMemReady is ignored outside FETCH/MEM_RD/MEM_WR.
- Reset mid-instruction (including mid-wait): immediate return to IDLE, write enables drop asynchronously, and no partial write-back completes.
- oIllegal clears only on reset.

Test Plan:
- Reset then ADD X3,X1,X2 (iOPCODE=10001011000), iMemReady tied 1 → states 0,1,2,3,8,1. oRegWrite=1 only in WB_ALU. oPCWrite=1 only in FETCH.
- LDUR (11111000010) with iMemReady low 3 cycles in MEM_RD → oMemRead=1,oIorD=1 held 4 cycles, then WB_MEM with oMemToReg=1,oRegWrite=1. Total 8 cycles.
- STUR (11111000000), iMemReady low 2 cycles → oMemWrite held 3 cycles, oRegWrite never 1, next state FETCH.
- CBZ (10110100xxx) with iZero=1 → BRANCH asserts oPCWrite=1,oOrigPC=1. Repeat with iZero=0 → oPCWrite=0. CBNZ gives the inverse.
- Opcode 00000000000 in DECODE → oIllegal=1 and stays 1; FSM returns to FETCH, no oRegWrite/oMemWrite.
- iRST_n pulsed low during MEM_WR wait → oMemWrite drops the same cycle, oState=0, oIllegal=0; fetch resumes after release.

Source files
------------

// File: rtl/control_multi_fsm.sv
// -----------------------------------------------------------------------------
// control_multi_fsm
// Multicycle LEGv8 control unit. A Moore FSM sequences the shared datapath
// (single instruction/data memory, one ALU, register bank, IR, A/B/ALUOut/MDR)
// through FETCH / DECODE / EXEC / MEM / WB and stalls on a memory handshake.
//
// Ports
//   iCLK, iRST_n   clock (rising edge), asynchronous active-low reset
//   iOPCODE[10:0]  IR[31:21], valid from DECODE onward
//   iZero          ALU zero flag (used in BRANCH)
//   iMemReady      memory finished the current read/write this cycle
//   oPCWrite       PC load enable         oIorD      mem addr 0=PC 1=ALUOut
//   oMemRead       memory read request    oMemWrite  memory write request
//   oIRWrite       IR load enable         oReg2Loc   2nd read reg 0=Rm 1=Rt
//   oOrigAULA      ALU A 0=PC 1=reg A     oOrigBULA  ALU B 00=B 01=4 10=imm 11=off<<2
//   oALUop         00 add, 01 pass B, 10 decode from opcode
//   oOrigPC        PC src 0=ALU 1=ALUOut  oMemToReg  WB 0=ALUOut 1=MDR
//   oRegWrite      register bank write    oIllegal   sticky unsupported opcode
//   oState         current state code (debug)
// -----------------------------------------------------------------------------
module control_multi_fsm #(
  parameter int ALUOP_W = 2,
  parameter int ST_W    = 4
) (
  input  logic               iCLK,
  input  logic               iRST_n,
  input  logic [10:0]        iOPCODE,
  input  logic               iZero,
  input  logic               iMemReady,
  output logic               oPCWrite,
  output logic               oIorD,
  output logic               oMemRead,
  output logic               oMemWrite,
  output logic               oIRWrite,
  output logic               oReg2Loc,
  output logic               oOrigAULA,
  output logic [1:0]         oOrigBULA,
  output logic [ALUOP_W-1:0] oALUop,
  output logic               oOrigPC,
  output logic               oMemToReg,
  output logic               oRegWrite,
  output logic               oIllegal,
  output logic [ST_W-1:0]    oState
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC_R   = 4'd3,
    S_EXEC_I   = 4'd4,
    S_MEM_ADDR = 4'd5,
    S_MEM_RD   = 4'd6,
    S_MEM_WR   = 4'd7,
    S_WB_ALU   = 4'd8,
    S_WB_MEM   = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11
  } state_e;

  typedef enum logic [2:0] {
    C_NONE = 3'd0,
    C_R    = 3'd1,
    C_I    = 3'd2,
    C_LD   = 3'd3,
    C_ST   = 3'd4,
    C_CBZ  = 3'd5,
    C_CBNZ = 3'd6,
    C_B    = 3'd7
  } class_e;

  // Opcode patterns; '?' bits are don't-care in the casez decode.
  localparam logic [10:0] OPC_ADD  = 11'b10001011000;
  localparam logic [10:0] OPC_SUB  = 11'b11001011000;
  localparam logic [10:0] OPC_AND  = 11'b10001010000;
  localparam logic [10:0] OPC_ORR  = 11'b10101010000;
  localparam logic [10:0] OPC_EOR  = 11'b11001010000;
  localparam logic [10:0] OPC_ADDI = 11'b1001000100?;
  localparam logic [10:0] OPC_SUBI = 11'b1101000100?;
  localparam logic [10:0] OPC_ANDI = 11'b1001001000?;
  localparam logic [10:0] OPC_ORRI = 11'b1011001000?;
  localparam logic [10:0] OPC_EORI = 11'b1101001000?;
  localparam logic [10:0] OPC_LDUR = 11'b11111000010;
  localparam logic [10:0] OPC_STUR = 11'b11111000000;
  localparam logic [10:0] OPC_CBZ  = 11'b10110100???;
  localparam logic [10:0] OPC_CBNZ = 11'b10110101???;
  localparam logic [10:0] OPC_B    = 11'b000101?????;

  localparam logic [ALUOP_W-1:0] ALU_ADD  = ALUOP_W'(2'b00);
  localparam logic [ALUOP_W-1:0] ALU_PASS = ALUOP_W'(2'b01);
  localparam logic [ALUOP_W-1:0] ALU_FUNC = ALUOP_W'(2'b10);

  function automatic class_e decode_op(input logic [10:0] opc);
    class_e c;
    casez (opc)
      OPC_ADD, OPC_SUB, OPC_AND, OPC_ORR, OPC_EOR:      c = C_R;
      OPC_ADDI, OPC_SUBI, OPC_ANDI, OPC_ORRI, OPC_EORI: c = C_I;
      OPC_LDUR:                                         c = C_LD;
      OPC_STUR:                                         c = C_ST;
      OPC_CBZ:                                          c = C_CBZ;
      OPC_CBNZ:                                         c = C_CBNZ;
      OPC_B:                                            c = C_B;
      default:                                          c = C_NONE;
    endcase
    return c;
  endfunction

  state_e state_q, state_d;
  class_e cls_q, cls_d;
  logic   illegal_q, illegal_d;
  class_e dec_s;

  assign dec_s    = decode_op(iOPCODE);
  assign oIllegal = illegal_q;
  assign oState   = ST_W'(state_q);

  // State, latched instruction class and sticky illegal flag.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q   <= S_IDLE;
      cls_q     <= C_NONE;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      illegal_q <= illegal_d;
    end
  end

  // Next-state logic; class is captured only in DECODE.
  always_comb begin
    state_d   = state_q;
    cls_d     = cls_q;
    illegal_d = illegal_q;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        if (iMemReady) state_d = S_DECODE;
        else           state_d = S_FETCH;
      end
      S_DECODE: begin
        cls_d = dec_s;
        case (dec_s)
          C_R:          state_d = S_EXEC_R;
          C_I:          state_d = S_EXEC_I;
          C_LD, C_ST:   state_d = S_MEM_ADDR;
          C_CBZ, C_CBNZ: state_d = S_BRANCH;
          C_B:          state_d = S_JUMP;
          default: begin
            // PC was already advanced in FETCH, so just move on.
            illegal_d = 1'b1;
            state_d   = S_FETCH;
          end
        endcase
      end
      S_EXEC_R, S_EXEC_I: state_d = S_WB_ALU;
      S_MEM_ADDR: begin
        if (cls_q == C_LD) state_d = S_MEM_RD;
        else               state_d = S_MEM_WR;
      end
      S_MEM_RD: begin
        if (iMemReady) state_d = S_WB_MEM;
        else           state_d = S_MEM_RD;
      end
      S_MEM_WR: begin
        if (iMemReady) state_d = S_FETCH;
        else           state_d = S_MEM_WR;
      end
      S_WB_ALU, S_WB_MEM, S_BRANCH, S_JUMP: state_d = S_FETCH;
      default: state_d = S_IDLE;
    endcase
  end

  // Moore output decode. Because state resets asynchronously, every write
  // enable drops the moment iRST_n goes low.
  always_comb begin
    oPCWrite  = 1'b0;
    oIorD     = 1'b0;
    oMemRead  = 1'b0;
    oMemWrite = 1'b0;
    oIRWrite  = 1'b0;
    oReg2Loc  = 1'b0;
    oOrigAULA = 1'b0;
    oOrigBULA = 2'b00;
    oALUop    = ALU_ADD;
    oOrigPC   = 1'b0;
    oMemToReg = 1'b0;
    oRegWrite = 1'b0;
    case (state_q)
      S_FETCH: begin
        oMemRead  = 1'b1;
        oOrigBULA = 2'b01;
        // IR and PC update only in the cycle the fetch completes.
        oIRWrite  = iMemReady;
        oPCWrite  = iMemReady;
      end
      S_DECODE: begin
        oOrigBULA = 2'b11;
        if (dec_s == C_CBZ || dec_s == C_CBNZ || dec_s == C_ST) oReg2Loc = 1'b1;
        else                                                   oReg2Loc = 1'b0;
      end
      S_EXEC_R: begin
        oOrigAULA = 1'b1;
        oOrigBULA = 2'b00;
        oALUop    = ALU_FUNC;
      end
      S_EXEC_I: begin
        oOrigAULA = 1'b1;
        oOrigBULA = 2'b10;
        oALUop    = ALU_FUNC;
      end
      S_MEM_ADDR: begin
        oOrigAULA = 1'b1;
        oOrigBULA = 2'b10;
      end
      S_MEM_RD: begin
        oMemRead = 1'b1;
        oIorD    = 1'b1;
      end
      S_MEM_WR: begin
        oMemWrite = 1'b1;
        oIorD     = 1'b1;
        oReg2Loc  = 1'b1;
      end
      S_WB_ALU: oRegWrite = 1'b1;
      S_WB_MEM: begin
        oRegWrite = 1'b1;
        oMemToReg = 1'b1;
      end
      S_BRANCH: begin
        oReg2Loc = 1'b1;
        oALUop   = ALU_PASS;
        oOrigPC  = 1'b1;
        oPCWrite = ((cls_q == C_CBZ) & iZero) | ((cls_q == C_CBNZ) & ~iZero);
      end
      S_JUMP: begin
        oPCWrite = 1'b1;
        oOrigPC  = 1'b1;
      end
      default: oPCWrite = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_control_multi_fsm.sv
// -----------------------------------------------------------------------------
// tb_control_multi_fsm
// Drives instructions one at a time. For each instruction the bench writes out
// the cycle-by-cycle script the control unit must follow (state code plus the
// full output bundle), derived from the instruction kind and the chosen number
// of memory wait cycles, and compares the DUT against it every cycle.
// -----------------------------------------------------------------------------
module tb_control_multi_fsm;

  localparam int K_R = 0, K_I = 1, K_LD = 2, K_ST = 3, K_CBZ = 4, K_CBNZ = 5, K_B = 6, K_ILL = 7;

  logic        iCLK = 1'b0;
  logic        iRST_n;
  logic [10:0] iOPCODE;
  logic        iZero;
  logic        iMemReady;
  logic        oPCWrite, oIorD, oMemRead, oMemWrite, oIRWrite, oReg2Loc, oOrigAULA;
  logic [1:0]  oOrigBULA;
  logic [1:0]  oALUop;
  logic        oOrigPC, oMemToReg, oRegWrite, oIllegal;
  logic [3:0]  oState;

  int   cnt_tests = 0;
  int   cnt_fail  = 0;
  logic ill_m     = 1'b0;

  control_multi_fsm #(.ALUOP_W(2), .ST_W(4)) dut (
    .iCLK(iCLK), .iRST_n(iRST_n), .iOPCODE(iOPCODE), .iZero(iZero),
    .iMemReady(iMemReady), .oPCWrite(oPCWrite), .oIorD(oIorD),
    .oMemRead(oMemRead), .oMemWrite(oMemWrite), .oIRWrite(oIRWrite),
    .oReg2Loc(oReg2Loc), .oOrigAULA(oOrigAULA), .oOrigBULA(oOrigBULA),
    .oALUop(oALUop), .oOrigPC(oOrigPC), .oMemToReg(oMemToReg),
    .oRegWrite(oRegWrite), .oIllegal(oIllegal), .oState(oState)
  );

  always #5 iCLK = ~iCLK;

  logic [14:0] dut_v;
  assign dut_v = {oPCWrite, oIorD, oMemRead, oMemWrite, oIRWrite, oReg2Loc, oOrigAULA,
                  oOrigBULA, oALUop, oOrigPC, oMemToReg, oRegWrite, oIllegal};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    cnt_tests++;
    if (got !== exp) begin
      cnt_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // Output bundle without the sticky illegal bit.
  function automatic logic [13:0] mk(input logic pcw, input logic iord, input logic mr,
                                     input logic mw, input logic irw, input logic r2l,
                                     input logic aa, input logic [1:0] bula,
                                     input logic [1:0] alu, input logic opc,
                                     input logic m2r, input logic rw);
    return {pcw, iord, mr, mw, irw, r2l, aa, bula, alu, opc, m2r, rw};
  endfunction

  function automatic logic [10:0] pick_op(input int kind);
    logic [10:0] r_tab [5];
    logic [9:0]  i_tab [5];
    logic [10:0] x_tab [4];
    r_tab = '{11'b10001011000, 11'b11001011000, 11'b10001010000, 11'b10101010000, 11'b11001010000};
    i_tab = '{10'b1001000100, 10'b1101000100, 10'b1001001000, 10'b1011001000, 10'b1101001000};
    x_tab = '{11'b00000000000, 11'b11111111111, 11'b11111000001, 11'b10001011001};
    case (kind)
      K_R:    return r_tab[$urandom_range(0, 4)];
      K_I:    return {i_tab[$urandom_range(0, 4)], rb()};
      K_LD:   return 11'b11111000010;
      K_ST:   return 11'b11111000000;
      K_CBZ:  return {8'b10110100, 3'($urandom)};
      K_CBNZ: return {8'b10110101, 3'($urandom)};
      K_B:    return {6'b000101, 5'($urandom)};
      default: return x_tab[$urandom_range(0, 3)];
    endcase
  endfunction

  // Called at a falling edge: drive inputs, check, advance to the next falling edge.
  task automatic step(input logic [3:0] st, input logic [13:0] ex, input logic rdy, input logic z);
    iMemReady = rdy;
    iZero     = z;
    #1;
    chk("state", 32'(oState), 32'(st));
    chk("outputs", 32'(dut_v), 32'({ex, ill_m}));
    @(negedge iCLK);
  endtask

  task automatic run_instr(input int kind, input int wf, input int wm, input int zsel,
                           input bit rst_mid);
    logic r;
    logic z;
    iOPCODE = 11'($urandom);
    for (int i = 0; i <= wf; i++) begin
      r = (i == wf);
      step(4'd1, mk(r, 1'b0, 1'b1, 1'b0, r, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0), r, rb());
    end
    iOPCODE = pick_op(kind);
    step(4'd2, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                  (kind == K_CBZ || kind == K_CBNZ || kind == K_ST),
                  1'b0, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0), rb(), rb());
    if (kind == K_ILL) ill_m = 1'b1;
    case (kind)
      K_R, K_I: begin
        step((kind == K_R) ? 4'd3 : 4'd4,
             mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                (kind == K_R) ? 2'b00 : 2'b10, 2'b10, 1'b0, 1'b0, 1'b0), rb(), rb());
        step(4'd8, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1), rb(), rb());
      end
      K_LD, K_ST: begin
        step(4'd5, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0), rb(), rb());
        for (int i = 0; i <= wm; i++) begin
          r = (i == wm);
          if (kind == K_LD) begin
            step(4'd6, mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0), r, rb());
          end else if (rst_mid && i == 1) begin
            iMemReady = 1'b0;
            #1;
            chk("memwr_before_rst", 32'(oMemWrite), 32'd1);
            #1 iRST_n = 1'b0;
            #1;
            chk("rst_memwrite", 32'(oMemWrite), 32'd0);
            chk("rst_state", 32'(oState), 32'd0);
            chk("rst_illegal", 32'(oIllegal), 32'd0);
            chk("rst_regwrite", 32'(oRegWrite | oPCWrite), 32'd0);
            ill_m = 1'b0;
            @(negedge iCLK);
            iRST_n = 1'b1;
            step(4'd0, 14'd0, rb(), rb());
            return;
          end else begin
            step(4'd7, mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0), r, rb());
          end
        end
        if (kind == K_LD)
          step(4'd9, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1), rb(), rb());
      end
      K_CBZ, K_CBNZ: begin
        z = (zsel < 0) ? rb() : zsel[0];
        step(4'd10, mk((kind == K_CBZ) ? z : ~z, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
                       2'b00, 2'b01, 1'b1, 1'b0, 1'b0), rb(), z);
      end
      K_B: begin
        step(4'd11, mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0), rb(), rb());
      end
      default: ;
    endcase
  endtask

  initial begin
    iRST_n    = 1'b0;
    iOPCODE   = 11'd0;
    iZero     = 1'b0;
    iMemReady = 1'b0;
    repeat (3) @(negedge iCLK);
    step(4'd0, 14'd0, 1'b1, 1'b1);   // held in reset
    iRST_n = 1'b1;
    step(4'd0, 14'd0, 1'b1, 1'b0);   // IDLE one cycle after release

    // Directed scenarios.
    run_instr(K_R,    0, 0, -1, 1'b0);
    run_instr(K_LD,   0, 3, -1, 1'b0);
    run_instr(K_ST,   1, 2, -1, 1'b0);
    run_instr(K_CBZ,  0, 0,  1, 1'b0);
    run_instr(K_CBZ,  0, 0,  0, 1'b0);
    run_instr(K_CBNZ, 0, 0,  1, 1'b0);
    run_instr(K_CBNZ, 0, 0,  0, 1'b0);
    run_instr(K_B,    0, 0, -1, 1'b0);
    run_instr(K_ILL,  0, 0, -1, 1'b0);
    run_instr(K_I,    2, 0, -1, 1'b0);

    // Randomized instruction stream.
    for (int n = 0; n < 200; n++) begin
      run_instr($urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 3), -1, 1'b0);
    end

    // Reset in the middle of a store wait, with the illegal flag set beforehand.
    run_instr(K_ILL, 0, 0, -1, 1'b0);
    run_instr(K_ST,  0, 3, -1, 1'b1);
    run_instr(K_R,   1, 0, -1, 1'b0);
    run_instr(K_LD,  0, 1, -1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", cnt_tests, cnt_fail);
    $finish;
  end

endmodule
